fp8_int_encoder: RTL and testbench

- Converts a signed two's-complement integer into the team's 8-bit minifloat format: sign[7], exponent[6:3] with bias 7, mantissa[2:0] with a hidden leading one.
- It is the producing end for the fp8 adder datapath: it generates the operands that the adder consumes.
- Normalisation is sequential, one bit position per cycle, followed by one rounding cycle.
- Valid/ready handshake on both sides.

---
 rtl/fp8_pkg.sv | 20 ++
 rtl/fp8_round_pack.sv | 43 ++++
 rtl/fp8_int_encoder.sv | 114 +++++++++++
 tb/tb_fp8_int_encoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fp8_pkg.sv
// Shared fp8 minifloat constants and encoder state type.
// Byte layout: {sign, exp[3:0] (bias 7), mant[2:0] (hidden leading one)}.
package fp8_pkg;

   localparam int FP8_EXP_BIAS = 7;
   localparam int FP8_EXP_MAX  = 14;
   localparam int FP8_EXP_W    = 4;
   localparam int FP8_MANT_W   = 3;

   localparam logic [6:0] FP8_SAT_MAG = 7'h78;
   localparam logic [7:0] FP8_ZERO    = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_NORM  = 2'd1,
      ST_ROUND = 2'd2,
      ST_DONE  = 2'd3
   } enc_state_e;

endpackage

// File: rtl/fp8_round_pack.sv
// Round-to-nearest-even and pack of a normalised magnitude into an fp8 byte.
// The magnitude is expected with its leading one at bit IN_W-1; pos is the
// unbiased exponent of that bit. An unnormalised (zero) magnitude packs to 0x00.
module fp8_round_pack
   import fp8_pkg::*;
#(
   parameter int IN_W  = 12,
   parameter int POS_W = 4
) (
   input  logic [IN_W-1:0]  mag,
   input  logic [POS_W-1:0] pos,
   input  logic             sign,
   output logic [7:0]       fp8_byte
);

   // Bits below the guard bit; empty (all-zero mask) when IN_W is 5.
   localparam logic [IN_W-1:0] STICKY_MASK = IN_W'((1 << (IN_W - 5)) - 1);

   logic [FP8_MANT_W-1:0] mant_trunc;
   logic                  guard;
   logic                  sticky;
   logic                  round_up;
   logic [FP8_MANT_W:0]   mant_sum;
   logic [5:0]            exp_full;

   // Round, propagate mantissa carry into the exponent, saturate above the top normal exponent.
   always_comb begin
      mant_trunc = mag[IN_W-2 -: FP8_MANT_W];
      guard      = mag[IN_W-5];
      sticky     = |(mag & STICKY_MASK);
      round_up   = guard & (sticky | mant_trunc[0]);
      mant_sum   = {1'b0, mant_trunc} + {{FP8_MANT_W{1'b0}}, round_up};
      exp_full   = 6'(pos) + 6'(FP8_EXP_BIAS) + {5'b0, mant_sum[FP8_MANT_W]};
      if (!mag[IN_W-1]) begin
         fp8_byte = FP8_ZERO;
      end else if (exp_full > 6'(FP8_EXP_MAX)) begin
         fp8_byte = {sign, FP8_SAT_MAG};
      end else begin
         fp8_byte = {sign, exp_full[FP8_EXP_W-1:0], mant_sum[FP8_MANT_W-1:0]};
      end
   end

endmodule

// File: rtl/fp8_int_encoder.sv
// Signed integer to fp8 minifloat encoder. Normalises one bit per cycle,
// then spends one cycle rounding/packing; valid/ready on both sides.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | waiting for an input; in_ready high while ena
//   ST_NORM  | shifting mag left until its msb is set, tracking pos
//   ST_ROUND | round/pack the normalised magnitude into out_data
//   ST_DONE  | presenting out_data until the consumer takes it
module fp8_int_encoder
   import fp8_pkg::*;
#(
   parameter int IN_W = 12
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IN_W-1:0] in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [7:0]      out_data
);

   localparam int POS_W = $clog2(IN_W);

   enc_state_e       state;
   enc_state_e       state_nxt;
   logic             sign;
   logic [IN_W-1:0]  mag;
   logic [IN_W-1:0]  in_mag;
   logic [POS_W-1:0] pos;
   logic [7:0]       round_byte;
   logic             accept;

   assign in_ready = ena && (state == ST_IDLE);
   assign accept   = in_valid && in_ready;
   // Unsigned view makes the most negative input exact: |-2^(IN_W-1)| = 2^(IN_W-1).
   assign in_mag   = in_data[IN_W-1] ? (~in_data + 1'b1) : in_data;

   fp8_round_pack #(
      .IN_W  (IN_W),
      .POS_W (POS_W)
   ) u_round_pack (
      .mag      (mag),
      .pos      (pos),
      .sign     (sign),
      .fp8_byte (round_byte)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else if (ena) begin
         state <= state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = (in_mag == '0) ? ST_DONE : ST_NORM;
         ST_NORM:  if (mag[IN_W-1]) state_nxt = ST_ROUND;
         ST_ROUND: state_nxt = ST_DONE;
         ST_DONE:  if (out_valid && out_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: operand capture, normalising shift, result register and out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign      <= 1'b0;
         mag       <= '0;
         pos       <= '0;
         out_data  <= FP8_ZERO;
         out_valid <= 1'b0;
      end else if (ena) begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  sign <= in_data[IN_W-1];
                  mag  <= in_mag;
                  pos  <= POS_W'(IN_W - 1);
                  if (in_mag == '0) out_data <= FP8_ZERO;
               end
            end
            ST_NORM: begin
               if (!mag[IN_W-1]) begin
                  mag <= mag << 1;
                  pos <= pos - 1'b1;
               end
            end
            ST_ROUND: begin
               out_data  <= round_byte;
               out_valid <= 1'b1;
            end
            ST_DONE: begin
               // The zero shortcut enters DONE with out_valid low; raise it one cycle later.
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp8_int_encoder.sv
// Directed bench for fp8_int_encoder at IN_W=12: a vector table with
// hand-computed bytes and latencies, plus sequences for reset, backpressure
// and enable.
module tb_fp8_int_encoder;

   localparam int IN_W = 12;
   localparam int TMO  = 100;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            ena;
   logic            in_valid;
   logic            in_ready;
   logic [IN_W-1:0] in_data;
   logic            out_valid;
   logic            out_ready;
   logic [7:0]      out_data;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [IN_W-1:0] din;
      logic [7:0]      dout;
      int              lat;
   } vec_t;

   vec_t vecs[15];

   fp8_int_encoder #(.IN_W(IN_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Present one input, count edges from the accepting edge to out_valid, then drain.
   task automatic run_vec(input logic [IN_W-1:0] din, output logic [7:0] dout, output int lat);
      in_valid = 1'b1;
      in_data  = din;
      tick();
      in_valid = 1'b0;
      in_data  = IN_W'($urandom);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!out_valid && lat < TMO);
      dout = out_data;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] got;
      int         lat;

      // in, expected byte, edges from accept to out_valid (k+2, or 1 for zero)
      vecs[0]  = '{12'd1,    8'h38, 13};
      vecs[1]  = '{12'd9,    8'h51, 10};
      vecs[2]  = '{-12'sd3,  8'hC4, 12};
      vecs[3]  = '{12'd0,    8'h00, 1};
      vecs[4]  = '{12'd240,  8'h77, 6};
      vecs[5]  = '{12'd17,   8'h58, 9};
      vecs[6]  = '{12'd19,   8'h5A, 9};
      vecs[7]  = '{12'd241,  8'h77, 6};
      vecs[8]  = '{12'd25,   8'h5C, 9};
      vecs[9]  = '{12'd27,   8'h5E, 9};
      vecs[10] = '{12'd248,  8'h78, 6};
      vecs[11] = '{12'd2047, 8'h78, 3};
      vecs[12] = '{-12'sd19, 8'hDA, 9};
      vecs[13] = '{-12'sd1,  8'hB8, 13};
      vecs[14] = '{12'h800,  8'hF8, 2};

      rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #23;
      chk("reset out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset out_data", {24'b0, out_data}, 32'h00);
      rst_n = 1'b1;
      tick();
      chk("idle in_ready", {31'b0, in_ready}, 32'd1);

      for (int i = 0; i < 15; i++) begin
         run_vec(vecs[i].din, got, lat);
         chk($sformatf("vec%0d data", i), {24'b0, got}, {24'b0, vecs[i].dout});
         chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d back to idle", i), {31'b0, in_ready}, 32'd1);
      end

      // Reset in the middle of NORM; out_data still holds 0xF8 from the last vector.
      in_valid = 1'b1; in_data = 12'd1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("midreset out_valid", {31'b0, out_valid}, 32'd0);
      chk("midreset out_data", {24'b0, out_data}, 32'h00);
      #2;
      rst_n = 1'b1;
      tick();
      chk("post reset in_ready", {31'b0, in_ready}, 32'd1);
      chk("post reset out_valid", {31'b0, out_valid}, 32'd0);

      // Backpressure, then a back-to-back input offered during the output handshake.
      in_valid = 1'b1; in_data = 12'd9;
      tick();
      in_valid = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!out_valid && lat < TMO);
      chk("bp latency", lat, 10);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("bp hold data %0d", i), {24'b0, out_data}, 32'h51);
         chk($sformatf("bp hold in_ready %0d", i), {31'b0, in_ready}, 32'd0);
      end
      chk("bp still valid", {31'b0, out_valid}, 32'd1);
      out_ready = 1'b1; in_valid = 1'b1; in_data = 12'd19;
      tick();
      out_ready = 1'b0;
      chk("bp released out_valid", {31'b0, out_valid}, 32'd0);
      chk("bp idle in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("b2b accepted", {31'b0, in_ready}, 32'd0);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!out_valid && lat < TMO);
      chk("b2b latency", lat, 9);
      chk("b2b data", {24'b0, out_data}, 32'h5A);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // ena low for 4 edges mid-NORM stretches latency from 13 to 17.
      in_valid = 1'b1; in_data = 12'd1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      do begin
         ena = (lat >= 3 && lat <= 6) ? 1'b0 : 1'b1;
         tick();
         lat++;
         if (lat == 5) chk("ena low in_ready", {31'b0, in_ready}, 32'd0);
      end while (!out_valid && lat < TMO);
      ena = 1'b1;
      chk("ena latency", lat, 17);
      chk("ena data", {24'b0, out_data}, 32'h38);
      ena = 1'b0; out_ready = 1'b1;
      tick();
      chk("ena low blocks handshake", {31'b0, out_valid}, 32'd1);
      chk("ena low data stable", {24'b0, out_data}, 32'h38);
      ena = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("ena high handshake", {31'b0, out_valid}, 32'd0);

      // ena low in IDLE: in_valid is ignored.
      ena = 1'b0; in_valid = 1'b1; in_data = 12'd5;
      #1;
      chk("idle ena low in_ready", {31'b0, in_ready}, 32'd0);
      repeat (3) tick();
      ena = 1'b1; in_valid = 1'b0;
      tick();
      chk("idle ena low not accepted", {31'b0, in_ready}, 32'd1);
      chk("idle ena low no output", {31'b0, out_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
